// File: rtl/tdm_demux_bmsce.sv
// De-interleaves a framed single-bit TDM stream into NCH parallel W-bit channel words.
// Latency: a channel word and its strobe appear one clock after the beat carrying its last bit.
// Backpressure: none; din_valid gates every beat and non-beat cycles hold all state.
module tdm_demux_bmsce #(
    parameter int NCH = 2,
    parameter int W   = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               din,
    input  logic               din_valid,
    input  logic               fsync,
    output logic [NCH*W-1:0]   ch_data,
    output logic [NCH-1:0]     ch_valid,
    output logic               frame_done,
    output logic               sync_err
);

    localparam int BW = $clog2(W + 1);
    localparam int CW = (NCH > 2) ? $clog2(NCH) : 1;
    localparam logic [BW-1:0] BIT_LAST = BW'(W - 1);
    localparam logic [CW-1:0] CH_LAST  = CW'(NCH - 1);

    typedef enum logic {
        HUNT = 1'b0,
        RECV = 1'b1
    } state_t;

    state_t             state_q,      state_d;
    logic [BW-1:0]      bit_cnt_q,    bit_cnt_d;
    logic [CW-1:0]      ch_cnt_q,     ch_cnt_d;
    // Only W-1 bits need storing: the last bit of a word comes straight from din.
    logic [W-2:0]       shift_q,      shift_d;
    logic [NCH*W-1:0]   ch_data_q,    ch_data_d;
    logic [NCH-1:0]     ch_valid_q,   ch_valid_d;
    logic               frame_done_q, frame_done_d;
    logic               sync_err_q,   sync_err_d;
    logic [W-1:0]       word;

    // Next-state: frame hunting, bit/channel counting and word completion.
    always_comb begin
        state_d      = state_q;
        bit_cnt_d    = bit_cnt_q;
        ch_cnt_d     = ch_cnt_q;
        shift_d      = shift_q;
        ch_data_d    = ch_data_q;
        ch_valid_d   = '0;
        frame_done_d = 1'b0;
        sync_err_d   = 1'b0;
        word         = {shift_q, din};

        if (din_valid) begin
            if (fsync) begin
                // A sync beat always starts a new frame; in RECV the partial frame is dropped.
                sync_err_d = (state_q == RECV);
                shift_d    = (W-1)'(din);
                bit_cnt_d  = BW'(1);
                ch_cnt_d   = '0;
                state_d    = RECV;
            end else if (state_q == RECV) begin
                shift_d = word[W-2:0];
                if (bit_cnt_q == BIT_LAST) begin
                    ch_data_d[int'(ch_cnt_q)*W +: W] = word;
                    ch_valid_d[ch_cnt_q]             = 1'b1;
                    bit_cnt_d                        = '0;
                    if (ch_cnt_q == CH_LAST) begin
                        // Each frame needs its own fsync, so go back to hunting.
                        frame_done_d = 1'b1;
                        ch_cnt_d     = '0;
                        state_d      = HUNT;
                    end else begin
                        ch_cnt_d = ch_cnt_q + 1'b1;
                    end
                end else begin
                    bit_cnt_d = bit_cnt_q + 1'b1;
                end
            end
        end
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= HUNT;
            bit_cnt_q    <= '0;
            ch_cnt_q     <= '0;
            shift_q      <= '0;
            ch_data_q    <= '0;
            ch_valid_q   <= '0;
            frame_done_q <= 1'b0;
            sync_err_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            bit_cnt_q    <= bit_cnt_d;
            ch_cnt_q     <= ch_cnt_d;
            shift_q      <= shift_d;
            ch_data_q    <= ch_data_d;
            ch_valid_q   <= ch_valid_d;
            frame_done_q <= frame_done_d;
            sync_err_q   <= sync_err_d;
        end
    end

    assign ch_data    = ch_data_q;
    assign ch_valid   = ch_valid_q;
    assign frame_done = frame_done_q;
    assign sync_err   = sync_err_q;

endmodule

// File: tb/tb_tdm_demux_bmsce.sv
// Directed bench for tdm_demux_bmsce (NCH=2, W=8) with a strobe scoreboard.
// Stimulus pushes the expected strobe event and its cycle; a negedge monitor pops and compares.
// Direct checks cover reset values and hold behaviour between strobes.
module tb_tdm_demux_bmsce;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        din = 1'b0;
    logic        din_valid = 1'b0;
    logic        fsync = 1'b0;
    logic [15:0] ch_data;
    logic [1:0]  ch_valid;
    logic        frame_done;
    logic        sync_err;

    tdm_demux_bmsce #(.NCH(2), .W(8)) dut (
        .clk        (clk),
        .rst        (rst),
        .din        (din),
        .din_valid  (din_valid),
        .fsync      (fsync),
        .ch_data    (ch_data),
        .ch_valid   (ch_valid),
        .frame_done (frame_done),
        .sync_err   (sync_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          cyc;
        logic [1:0]  cv;
        logic        fd;
        logic        se;
        logic [15:0] data;
    } exp_t;

    exp_t        sb[$];
    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    logic [15:0] exp_data = 16'h0000;

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: every strobe must match the oldest pending expectation, on its exact cycle.
    always @(negedge clk) begin
        exp_t e;
        while (sb.size() > 0 && sb[0].cyc < cyc) begin
            e = sb.pop_front();
            checks++;
            errors++;
            $display("FAIL missed_strobe expected at cyc=%0d cv=%b fd=%b se=%b data=%h, not observed by cyc=%0d",
                     e.cyc, e.cv, e.fd, e.se, e.data, cyc);
        end
        if (ch_valid != 2'b00 || frame_done || sync_err) begin
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL unexpected_strobe cyc=%0d cv=%b fd=%b se=%b data=%h",
                         cyc, ch_valid, frame_done, sync_err, ch_data);
            end else begin
                e = sb.pop_front();
                if (e.cyc != cyc || e.cv !== ch_valid || e.fd !== frame_done ||
                    e.se !== sync_err || e.data !== ch_data) begin
                    errors++;
                    $display("FAIL strobe_event actual cyc=%0d cv=%b fd=%b se=%b data=%h required cyc=%0d cv=%b fd=%b se=%b data=%h",
                             cyc, ch_valid, frame_done, sync_err, ch_data,
                             e.cyc, e.cv, e.fd, e.se, e.data);
                end
            end
        end
    end

    task automatic push(input logic [1:0] cv, input logic fd, input logic se, input logic [15:0] d);
        exp_t e;
        e.cyc  = cyc;
        e.cv   = cv;
        e.fd   = fd;
        e.se   = se;
        e.data = d;
        sb.push_back(e);
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    // One beat, optionally preceded by idle cycles carrying random din/fsync with din_valid low.
    task automatic beat(input logic d, input logic fs, input int gap);
        repeat (gap) begin
            din_valid = 1'b0;
            din       = 1'($urandom);
            fsync     = 1'($urandom);
            @(posedge clk); #1;
        end
        din       = d;
        fsync     = fs;
        din_valid = 1'b1;
        @(posedge clk); #1;
        din_valid = 1'b0;
        fsync     = 1'b0;
    endtask

    task automatic send_word(input logic [7:0] w, input int ch, input logic sync, input int gap);
        for (int i = 7; i >= 0; i--) beat(w[i], sync && (i == 7), gap);
        exp_data[ch*8 +: 8] = w;
        push((ch == 0) ? 2'b01 : 2'b10, ch == 1, 1'b0, exp_data);
    endtask

    task automatic send_frame(input logic [7:0] c0, input logic [7:0] c1, input int gap);
        send_word(c0, 0, 1'b1, gap);
        send_word(c1, 1, 1'b0, gap);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        repeat (2) begin
            din       = 1'($urandom);
            din_valid = 1'($urandom);
            fsync     = 1'($urandom);
            @(posedge clk); #1;
        end
        chk("reset_ch_data", 32'(ch_data), 32'h0);
        chk("reset_strobes", 32'({ch_valid, frame_done, sync_err}), 32'h0);
        rst       = 1'b0;
        din_valid = 1'b0;
        fsync     = 1'b0;
        exp_data  = 16'h0000;
    endtask

    initial begin
        logic [7:0] v;
        // Reset and release: no strobes may follow.
        do_reset();
        repeat (3) begin @(posedge clk); #1; end

        // Clean contiguous frame.
        send_word(8'hA5, 0, 1'b1, 0);
        chk("clean_ch0", 32'(ch_data), 32'h00A5);
        send_word(8'h3C, 1, 1'b0, 0);
        chk("clean_frame", 32'(ch_data), 32'h3CA5);

        // Stalled frame: three idle cycles before every beat.
        send_frame(8'hA5, 8'h3C, 3);
        chk("stalled_frame", 32'(ch_data), 32'h3CA5);

        // Mid-frame resync.
        send_frame(8'h11, 8'h22, 0);
        chk("pre_resync", 32'(ch_data), 32'h2211);
        send_word(8'hFF, 0, 1'b1, 0);
        beat(1'b1, 1'b0, 0);
        beat(1'b1, 1'b0, 0);
        v = 8'h5A;
        for (int i = 7; i >= 0; i--) begin
            beat(v[i], i == 7, 0);
            if (i == 7) push(2'b00, 1'b0, 1'b1, exp_data);
        end
        exp_data[7:0] = 8'h5A;
        push(2'b01, 1'b0, 1'b0, exp_data);
        chk("resync_ch1_held", 32'(ch_data[15:8]), 32'h22);
        send_word(8'hC3, 1, 1'b0, 0);
        chk("resync_final", 32'(ch_data), 32'hC35A);

        // Twenty beats with no fsync: nothing happens.
        repeat (20) beat(1'($urandom), 1'b0, 0);
        chk("hunt_hold", 32'(ch_data), 32'hC35A);

        // Back-to-back frames, zero gap between them.
        send_frame(8'h12, 8'h34, 0);
        send_frame(8'h56, 8'h78, 0);
        chk("back_to_back", 32'(ch_data), 32'h7856);

        // Reset after five bits of a frame.
        v = 8'h99;
        for (int i = 7; i >= 3; i--) beat(v[i], i == 7, 0);
        do_reset();
        repeat (2) begin @(posedge clk); #1; end
        send_frame(8'h0F, 8'hF0, 0);
        chk("post_reset_frame", 32'(ch_data), 32'hF00F);

        repeat (5) begin @(posedge clk); #1; end
        chk("scoreboard_drained", 32'(sb.size()), 32'h0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/tdm_demux_bmsce.md
Name: tdm_demux_bmsce

Overview:
- Receive-side counterpart of the team's 2:1 channel mux.
- Takes a single-bit time-division-multiplexed serial stream framed by a sync strobe and de-interleaves it back into NCH parallel channel words of W bits each.
- Sits at the far end of the serial link and presents registered per-channel words with one-cycle valid strobes to downstream logic.

Parameters:
- NCH, 2, number of channels per frame (>=2).
- W, 8, bits per channel word (>=2).

Ports:
- clk  input  1  system clock; all logic on rising edge.
- rst  input  1  synchronous, active-high reset.
- din  input  1  serial data bit, MSB of each channel first.
- din_valid  input  1  din/fsync sampled only when high.
- fsync  input  1  marks bit 0 of channel 0 of a frame; qualified by din_valid.
- ch_data  output  NCH*W  channel k word at [k*W+W-1 : k*W].
- ch_valid  output  NCH  one-cycle pulse per channel when its word updates.
- frame_done  output  1  one-cycle pulse when the last channel of a frame updates.
- sync_err  output  1  one-cycle pulse on fsync arriving mid-frame.

Interface decision: one clock, clk; reset rst is synchronous and active-high.

Behaviour:
- Reset (rst high at clock edge, overrides everything):
  - ch_data, ch_valid, frame_done and sync_err all 0.
  - State = HUNT; counters cleared.
- A "beat" is a clock edge with din_valid=1. Non-beat cycles hold all state and counters; strobe outputs are 0.
- States: HUNT, RECV.
  - HUNT: beats with fsync=0 are ignored, with no output change. A beat with fsync=1 loads din as bit W-1 of channel 0 in the shift register, sets bit_cnt=1 and ch_cnt=0, then moves to RECV.
  - RECV: each beat shifts din in MSB-first and increments bit_cnt.
- Channel completion: on the beat where bit_cnt reaches W (the W-th bit of the word):
  - Next cycle: ch_data slice ch_cnt <= assembled word, and ch_valid[ch_cnt] pulses 1 cycle. This is a latency of one clock after the last bit's beat.
  - bit_cnt <= 0; ch_cnt increments.
- Frame completion: when channel NCH-1 completes, frame_done pulses in the same cycle as ch_valid[NCH-1], and state returns to HUNT. The next frame therefore requires a fresh fsync, which may come on the very next beat (zero-gap back-to-back frames are supported).
- Mid-frame fsync: a beat with fsync=1 while in RECV.
  - sync_err pulses next cycle.
  - The partial word is discarded; ch_data slices not yet completed this frame keep their previous values.
  - That beat is taken as bit 0 of channel 0 of a new frame (bit_cnt=1, ch_cnt=0).
- fsync with din_valid=0 is ignored.
- ch_data holds between updates. Each channel slice is written only by its own completion.
- Counter widths: bit_cnt is clog2(W+1), ch_cnt is clog2(NCH), with no wrap beyond the limits above.
- Reset mid-frame: the partial frame is lost with no strobes; state returns to HUNT.

Test Plan (NCH=2, W=8):
- Reset check: hold rst for 2 cycles with random din and din_valid -> all outputs 0; HUNT is entered; no strobes on release.
- Clean frame: contiguous beats, fsync on the first beat, bits 0xA5 then 0x3C MSB-first:
  - One cycle after beat 8: ch_valid=01 and ch_data[7:0]=0xA5.
  - One cycle after beat 16: ch_valid=10, frame_done=1, ch_data=0x3CA5.
- Stalled frame: same data with din_valid low for 3 cycles between every beat -> identical ch_data. Strobes come exactly one cycle after the 8th and 16th beats.
- Mid-frame resync: send a full frame 0x11/0x22, then start a frame 0xFF with fsync. Re-assert fsync on beat 11 (ch1 bit 2), then send 16 bits 0x5A/0xC3:
  - sync_err pulses once.
  - ch_data[15:8] stays 0x22 until the new frame completes.
  - Final ch_data=0xC35A.
- Hunt / no-sync and back-to-back frames:
  - 20 beats without fsync -> no strobes, ch_data unchanged.
  - Two frames 0x12/0x34 and 0x56/0x78 with fsync on the beat immediately after the first frame's last bit -> two frame_done pulses; final ch_data=0x7856.
- Reset mid-frame: assert rst after 5 bits -> outputs 0, no strobes. A following clean frame 0x0F/0xF0 decodes to ch_data=0xF00F.
